zigbee_cordic_vec: RTL and testbench

Parametrised, iterative CORDIC vectoring engine for the Zigbee receive path: converts one baseband I/Q sample into a quantised phase and a gain-scaled magnitude. Successor to the fixed 5-bit/6-bit CORDIC top. It adds configurable widths and iteration count, a ready/valid handshake on both sides, and a magnitude output. It sits between the baseband I/Q front end and the phase-differential demodulator.

---
 rtl/zigbee_cordic_vec_if.sv | 25 ++
 rtl/zigbee_cordic_vec.sv | 148 ++++++++++++++
 tb/tb_zigbee_cordic_vec.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/zigbee_cordic_vec_if.sv
// Handshake bundle for the Zigbee CORDIC vectoring engine.
// Sample side: InValid/InReady/Ibb/Qbb. Result side: OutValid/OutReady/Wout/Mag.
interface zigbee_cordic_vec_if #(
    parameter int IQ_SIZE = 5,
    parameter int W_SIZE  = 6
);
    logic                      InValid;
    logic                      InReady;
    logic signed [IQ_SIZE-1:0] Ibb;
    logic signed [IQ_SIZE-1:0] Qbb;
    logic                      OutValid;
    logic                      OutReady;
    logic [W_SIZE-1:0]         Wout;
    logic [IQ_SIZE:0]          Mag;

    modport master (
        output InValid, Ibb, Qbb, OutReady,
        input  InReady, OutValid, Wout, Mag
    );

    modport slave (
        input  InValid, Ibb, Qbb, OutReady,
        output InReady, OutValid, Wout, Mag
    );
endinterface

// File: rtl/zigbee_cordic_vec.sv
// Iterative CORDIC vectoring engine: I/Q sample -> quantised phase + magnitude.
// Ports: Clk, Rst (sync, active high), bus (slave side of zigbee_cordic_vec_if).
module zigbee_cordic_vec #(
    parameter int IQ_SIZE = 5,
    parameter int W_SIZE  = 6,
    parameter int ITER    = 8,
    parameter int GUARD   = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    zigbee_cordic_vec_if.slave   bus
);
    localparam int XW = IQ_SIZE + 2 + GUARD;
    localparam int ZW = W_SIZE + GUARD;

    localparam logic [ZW-1:0] Z_HALF  = ZW'(1) << (ZW - 1);
    localparam logic [ZW-1:0] Z_RND   = ZW'(1) << (GUARD - 1);
    localparam logic [XW:0]   X_RND   = (XW + 1)'(1) << (GUARD - 1);
    localparam logic [XW:0]   MAG_MAX = (XW + 1)'((1 << (IQ_SIZE + 1)) - 1);
    localparam logic [3:0]    LAST    = 4'(ITER - 1);

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    // atan(2^-i) in units of 2^-ZW turns, rounded to nearest
    function automatic logic [15:0][ZW-1:0] gen_atan();
        logic [15:0][ZW-1:0] lut;
        real pi;
        real a;
        pi = 3.14159265358979323846;
        for (int i = 0; i < 16; i++) begin
            a = $atan(1.0 / (2.0 ** i)) * (2.0 ** ZW) / (2.0 * pi);
            lut[i] = ZW'($rtoi(a + 0.5));
        end
        return lut;
    endfunction

    localparam logic [15:0][ZW-1:0] ATAN = gen_atan();

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic signed [XW-1:0]  x_q, y_q;
    logic [ZW-1:0]         z_q;
    logic                  zero_q;
    logic                  ov_q;
    logic [W_SIZE-1:0]     w_q;
    logic [IQ_SIZE:0]      m_q;

    logic signed [XW-1:0]  i_ext, q_ext;
    logic signed [XW-1:0]  x_cap, y_cap;
    logic [ZW-1:0]         z_cap;
    logic signed [XW-1:0]  xs, ys;
    logic signed [XW-1:0]  x_d, y_d;
    logic [ZW-1:0]         z_d;
    logic [ZW-1:0]         z_r;
    logic [XW:0]           x_r;
    logic [XW:0]           m_full;
    logic [W_SIZE-1:0]     w_d;
    logic [IQ_SIZE:0]      m_d;

    always_comb begin
        i_ext = {{2{bus.Ibb[IQ_SIZE-1]}}, bus.Ibb, {GUARD{1'b0}}};
        q_ext = {{2{bus.Qbb[IQ_SIZE-1]}}, bus.Qbb, {GUARD{1'b0}}};

        // left half-plane: rotate by 180 deg first so iterations converge
        if (bus.Ibb[IQ_SIZE-1]) begin
            x_cap = -i_ext;
            y_cap = -q_ext;
            z_cap = Z_HALF;
        end else begin
            x_cap = i_ext;
            y_cap = q_ext;
            z_cap = '0;
        end

        xs = x_q >>> cnt_q;
        ys = y_q >>> cnt_q;
        if (!y_q[XW-1]) begin
            x_d = x_q + ys;
            y_d = y_q - xs;
            z_d = z_q + ATAN[cnt_q];
        end else begin
            x_d = x_q - ys;
            y_d = y_q + xs;
            z_d = z_q - ATAN[cnt_q];
        end

        // truncation to W_SIZE bits gives the modulo wrap (2^W_SIZE -> 0)
        z_r = z_d + Z_RND;
        w_d = W_SIZE'(z_r >> GUARD);

        // x stays non-negative after pre-rotation
        x_r    = {1'b0, x_d} + X_RND;
        m_full = x_r >> GUARD;
        m_d    = (m_full > MAG_MAX) ? MAG_MAX[IQ_SIZE:0] : m_full[IQ_SIZE:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            ov_q    <= 1'b0;
            w_q     <= '0;
            m_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.InValid) begin
                        x_q     <= x_cap;
                        y_q     <= y_cap;
                        z_q     <= z_cap;
                        zero_q  <= (bus.Ibb == '0) && (bus.Qbb == '0);
                        cnt_q   <= '0;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        ov_q    <= 1'b1;
                        w_q     <= zero_q ? '0 : w_d;
                        m_q     <= zero_q ? '0 : m_d;
                    end
                end
                DONE: begin
                    if (bus.OutReady) begin
                        ov_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.InReady  = (state_q == IDLE) && !Rst;
    assign bus.OutValid = ov_q;
    assign bus.Wout     = w_q;
    assign bus.Mag      = m_q;
endmodule

// File: tb/tb_zigbee_cordic_vec.sv
// Testbench for zigbee_cordic_vec: default-parameter directed tests plus
// a random phase sweep on an IQ_SIZE=8, W_SIZE=8, ITER=12 instance.
module tb_zigbee_cordic_vec;
    logic Clk;
    logic Rst;
    int   errors;
    int   checks;

    typedef struct {
        string tag;
        int    w;
        int    mag;
        int    tol;
    } exp_t;

    exp_t sbq[$];

    zigbee_cordic_vec_if #(.IQ_SIZE(5), .W_SIZE(6)) bus1 ();
    zigbee_cordic_vec_if #(.IQ_SIZE(8), .W_SIZE(8)) bus2 ();

    zigbee_cordic_vec #(
        .IQ_SIZE(5), .W_SIZE(6), .ITER(8), .GUARD(4)
    ) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1.slave)
    );

    zigbee_cordic_vec #(
        .IQ_SIZE(8), .W_SIZE(8), .ITER(12), .GUARD(4)
    ) u_dut2 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus2.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_eq(input string tag, input integer obs,
                          input integer expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_rng(input string tag, input integer obs,
                           input integer expv, input integer tol);
        checks++;
        assert ((obs >= expv - tol && obs <= expv + tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d+-%0d", tag, obs, expv, tol);
        end
    endtask

    // drive one sample into the default DUT, check latency and result
    task automatic send1(input int i, input int q, input int w,
                         input int mag, input int tol, input string tag);
        exp_t e;
        int   n;
        int   lat;
        e.tag = tag;
        e.w   = w;
        e.mag = mag;
        e.tol = tol;
        sbq.push_back(e);
        bus1.Ibb     = 5'(i);
        bus1.Qbb     = 5'(q);
        bus1.InValid = 1'b1;
        n = 0;
        while (bus1.InReady !== 1'b1 && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        chk_eq({tag, "_inready"}, bus1.InReady, 1);
        @(posedge Clk); #1;
        bus1.InValid = 1'b0;
        lat = 0;
        while (bus1.OutValid !== 1'b1 && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        chk_eq({tag, "_lat"}, lat, 8);
        e = sbq.pop_front();
        chk_eq({e.tag, "_wout"}, integer'(bus1.Wout), e.w);
        chk_rng({e.tag, "_mag"}, integer'(bus1.Mag), e.mag, e.tol);
        @(posedge Clk); #1;
        chk_eq({e.tag, "_release"}, {bus1.OutValid, bus1.InReady}, 2'b01);
    endtask

    initial begin
        real pi;
        real kg;
        real th;
        real p;
        real d;
        real em;
        int  si;
        int  sq;
        int  n;

        errors = 0;
        checks = 0;
        pi     = 3.14159265358979323846;

        Rst           = 1'b1;
        bus1.InValid  = 1'b0;
        bus1.Ibb      = '0;
        bus1.Qbb      = '0;
        bus1.OutReady = 1'b1;
        bus2.InValid  = 1'b0;
        bus2.Ibb      = '0;
        bus2.Qbb      = '0;
        bus2.OutReady = 1'b1;

        repeat (2) @(posedge Clk);
        #1;
        chk_eq("rst_ovalid", bus1.OutValid, 0);
        chk_eq("rst_wout", bus1.Wout, 0);
        chk_eq("rst_mag", bus1.Mag, 0);
        chk_eq("rst_inready_low", bus1.InReady, 0);
        Rst = 1'b0;
        #1;
        chk_eq("rst_inready_high", bus1.InReady, 1);

        send1(15, 0, 0, 25, 1, "axis_0");
        send1(0, 15, 16, 25, 1, "axis_90");
        send1(-15, 0, 32, 25, 1, "axis_180");
        send1(0, -15, 48, 25, 1, "axis_270");
        send1(10, 10, 8, 23, 1, "diag");
        send1(-16, 0, 32, 26, 1, "neg_max");
        send1(-16, -16, 40, 37, 1, "corner");
        send1(0, 0, 0, 0, 0, "zero");
        send1(15, -1, 63, 25, 1, "wrap_neg");
        send1(15, 0, 0, 25, 1, "wrap_zero");

        // backpressure: result held, new input ignored
        bus1.OutReady = 1'b0;
        bus1.Ibb      = 5'(10);
        bus1.Qbb      = 5'(10);
        bus1.InValid  = 1'b1;
        @(posedge Clk); #1;
        bus1.InValid = 1'b0;
        n = 0;
        while (bus1.OutValid !== 1'b1 && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
        chk_eq("bp_lat", n, 8);
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk); #1;
            if (k == 5) begin
                bus1.InValid = 1'b1;
                bus1.Ibb     = 5'(0);
                bus1.Qbb     = 5'(15);
            end
            if (k == 7) bus1.InValid = 1'b0;
            chk_eq("bp_wout", bus1.Wout, 8);
            chk_rng("bp_mag", integer'(bus1.Mag), 23, 1);
            chk_eq("bp_ovalid", bus1.OutValid, 1);
            chk_eq("bp_inready", bus1.InReady, 0);
        end
        bus1.InValid  = 1'b0;
        bus1.OutReady = 1'b1;
        @(posedge Clk); #1;
        chk_eq("bp_drop", {bus1.OutValid, bus1.InReady}, 2'b01);
        chk_eq("bp_hold_wout", bus1.Wout, 8);

        // reset in the middle of rotation
        bus1.Ibb     = 5'(15);
        bus1.Qbb     = 5'(0);
        bus1.InValid = 1'b1;
        @(posedge Clk); #1;
        bus1.InValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk_eq("mid_rst_ovalid", bus1.OutValid, 0);
        chk_eq("mid_rst_wout", bus1.Wout, 0);
        chk_eq("mid_rst_mag", bus1.Mag, 0);
        chk_eq("mid_rst_inready_low", bus1.InReady, 0);
        Rst = 1'b0;
        #1;
        chk_eq("mid_rst_inready", bus1.InReady, 1);
        send1(0, 15, 16, 25, 1, "after_rst");

        // random sweep on the wide instance
        kg = 1.0;
        for (int i = 0; i < 12; i++) kg = kg * $sqrt(1.0 + 1.0 / (4.0 ** i));
        for (int s = 0; s < 300; s++) begin
            th = real'($urandom_range(0, 65535)) * 2.0 * pi / 65536.0;
            si = int'(120.0 * $cos(th));
            sq = int'(120.0 * $sin(th));
            bus2.Ibb     = 8'(si);
            bus2.Qbb     = 8'(sq);
            bus2.InValid = 1'b1;
            n = 0;
            while (bus2.InReady !== 1'b1 && n < 50) begin
                @(posedge Clk); #1;
                n++;
            end
            @(posedge Clk); #1;
            bus2.InValid = 1'b0;
            n = 0;
            while (bus2.OutValid !== 1'b1 && n < 40) begin
                @(posedge Clk); #1;
                n++;
            end
            chk_eq("sweep_lat", n, 12);
            p = $atan2(real'(sq), real'(si)) * 256.0 / (2.0 * pi);
            if (p < 0.0) p = p + 256.0;
            d = real'(bus2.Wout) - p;
            if (d > 128.0) d = d - 256.0;
            if (d < -128.0) d = d + 256.0;
            checks++;
            assert ((d <= 1.0 && d >= -1.0) === 1'b1) else begin
                errors++;
                $error("FAIL sweep_phase: got %0d want %f (I=%0d Q=%0d)",
                       bus2.Wout, p, si, sq);
            end
            em = $sqrt(real'(si * si + sq * sq)) * kg;
            checks++;
            assert ((real'(bus2.Mag) - em <= 2.0 &&
                     real'(bus2.Mag) - em >= -2.0) === 1'b1) else begin
                errors++;
                $error("FAIL sweep_mag: got %0d want %f", bus2.Mag, em);
            end
            @(posedge Clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
